wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback pipeline stage. Sits between the memory stage and the general purpose register file.
- Registers the memory-stage result and aligns and extends load data.
- Drives the register-file write port: we_n, wr_addr, wr_data.
- Counts retired instructions and publishes the destination tag for hazard logic.

Parameters:
- WORD_WIDTH, 32, datapath width.
- GPR_ADDR_WIDTH, 5, register index width.
- CNT_WIDTH, 64, retired-instruction counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mem_valid  in  1  memory stage holds a valid instruction
- mem_rd_we  in  1  instruction writes a destination register
- mem_rd_addr  in  GPR_ADDR_WIDTH  destination index
- mem_alu_result  in  WORD_WIDTH  non-load result
- mem_is_load  in  1  result comes from load data
- mem_load_type  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- mem_addr_lsb  in  2  byte offset of the load address
- mem_load_data  in  WORD_WIDTH  raw word from the data bus
- wb_stall  in  1  hold the stage contents
- wb_flush  in  1  invalidate the stage contents
- gpr_we_n  out  1  register-file write enable, 0 = write
- gpr_wr_addr  out  GPR_ADDR_WIDTH  register-file write index
- gpr_wr_data  out  WORD_WIDTH  register-file write data
- wb_valid  out  1  stage holds a valid instruction
- wb_rd_addr  out  GPR_ADDR_WIDTH  destination tag for the hazard unit; 0 when no write is pending
- instret  out  CNT_WIDTH  retired-instruction count

Behaviour:
- Reset state: wb_valid=0, gpr_we_n=1, gpr_wr_addr=0, gpr_wr_data=0, wb_rd_addr=0, instret=0, internal fired flag=0.
- Capture at each posedge, in priority order:
  - wb_flush=1: wb_valid<=0 and fired<=0. Flush wins over stall and over new input.
  - wb_stall=1: all stage registers hold.
  - Otherwise: capture mem_* into the stage registers, wb_valid<=mem_valid, fired<=0.
- Load alignment happens before the register, so wr_data is a registered value:
  - Byte lane = mem_addr_lsb; LB/LBU select bits [8*lsb+7 : 8*lsb].
  - Halfword lane = mem_addr_lsb[1]; LH/LHU select [16*lsb[1]+15 : 16*lsb[1]]. mem_addr_lsb[0] is ignored, since misalignment is trapped upstream.
  - LB and LH sign-extend. LBU and LHU zero-extend. LW passes the word through.
  - Reserved funct3 values pass the full word through.
  - mem_is_load=0 selects mem_alu_result.
- Write rule: gpr_we_n=0 only when wb_valid=1, rd_we=1, rd_addr!=0 and fired=0.
  - The write lasts exactly one cycle per instruction, even under a multi-cycle stall.
  - fired is set at the posedge following the first valid cycle and stays set while stalled.
- gpr_wr_addr and gpr_wr_data are the stage registers and are stable whenever gpr_we_n=0.
- wb_rd_addr equals the stage rd_addr when wb_valid & rd_we & ~fired, otherwise 0.
- Retirement: instret increments by 1 at the posedge ending a cycle with wb_valid=1 and fired=0, whether or not the instruction writes a register.
  - instret wraps from 2^CNT_WIDTH-1 to 0.
  - A flush does not retract a retirement already counted.
- Write to x0: no write occurs, but the instruction still retires.
- Stall and flush both asserted: the flush takes effect and the entry is dropped. If that entry had not yet fired, it neither writes nor retires.
- Reset mid-stall or mid-write: all outputs return to reset values asynchronously, and no write is issued after reset release until a new valid capture.
- Latency: one cycle from a valid mem_* sample to gpr_we_n=0. Back-to-back instructions write on consecutive cycles.

Decomposition:
- Shared package (the existing define header): WORD_WIDTH, GPR_ADDR_WIDTH, GPR_WRITE=1'b0, GPR_READ=1'b1, and LB/LH/LW/LBU/LHU funct3 constants.
- One combinational sub-module, load_align, maps (load_type, addr_lsb, load_data) to an aligned, extended word. The pipeline register, fired flag and counter stay in wb_stage.

Test Plan:
- ALU writeback: mem_valid=1, rd_we=1, rd=5, alu=0xDEADBEEF, not a load. One cycle later gpr_we_n=0, wr_addr=5, wr_data=0xDEADBEEF, instret=1 the following cycle.
- Load extension: load_data=0x80F07F12.
  - LB, lsb=3 -> 0xFFFFFF80.
  - LBU, lsb=3 -> 0x00000080.
  - LH, lsb=2 -> 0xFFFF80F0.
  - LHU, lsb=0 -> 0x00007F12.
  - LW -> 0x80F07F12.
- x0 suppression: rd=0, rd_we=1, valid. gpr_we_n stays 1, wb_rd_addr=0, instret still increments by 1.
- Stall hold: capture rd=7, then wb_stall=1 for 4 cycles. Exactly one gpr_we_n=0 pulse, instret +1 only, outputs held, wb_rd_addr=0 after the first cycle.
- Flush priority: capture rd=9, then assert wb_stall=1 and wb_flush=1 together. The next cycle has wb_valid=0, and a subsequent stall produces no write.
- Counter wrap: preload instret near 2^64-1 by force, retire 2 instructions. Sequence is ...FFFF -> 0 -> 1. Asserting rst_n low mid-stream clears everything immediately.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// -----------------------------------------------------------------------------
// wb_stage_pkg
// Shared constants for the writeback stage: datapath and register-index
// widths, register-file write-enable polarity and the load funct3 encodings.
// -----------------------------------------------------------------------------
package wb_stage_pkg;

   localparam int WORD_WIDTH     = 32;
   localparam int GPR_ADDR_WIDTH = 5;
   localparam int CNT_WIDTH      = 64;

   // Register-file write enable is active low.
   localparam logic GPR_WRITE = 1'b0;
   localparam logic GPR_READ  = 1'b1;

   // Load funct3 encodings.
   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

endpackage : wb_stage_pkg

// File: rtl/wb_stage_if.sv
// -----------------------------------------------------------------------------
// wb_stage_if
// Memory-stage to writeback-stage bundle.
//   mem_valid      : memory stage holds a valid instruction
//   mem_rd_we      : instruction writes a destination register
//   mem_rd_addr    : destination register index
//   mem_alu_result : non-load result
//   mem_is_load    : result comes from load data
//   mem_load_type  : load funct3
//   mem_addr_lsb   : byte offset of the load address
//   mem_load_data  : raw word from the data bus
// master = memory stage (driver), slave = writeback stage (receiver).
// -----------------------------------------------------------------------------
interface wb_stage_if #(
   parameter int WORD_WIDTH     = wb_stage_pkg::WORD_WIDTH,
   parameter int GPR_ADDR_WIDTH = wb_stage_pkg::GPR_ADDR_WIDTH
);

   logic                      mem_valid;
   logic                      mem_rd_we;
   logic [GPR_ADDR_WIDTH-1:0] mem_rd_addr;
   logic [WORD_WIDTH-1:0]     mem_alu_result;
   logic                      mem_is_load;
   logic [2:0]                mem_load_type;
   logic [1:0]                mem_addr_lsb;
   logic [WORD_WIDTH-1:0]     mem_load_data;

   modport master (
      output mem_valid, mem_rd_we, mem_rd_addr, mem_alu_result,
             mem_is_load, mem_load_type, mem_addr_lsb, mem_load_data
   );

   modport slave (
      input  mem_valid, mem_rd_we, mem_rd_addr, mem_alu_result,
             mem_is_load, mem_load_type, mem_addr_lsb, mem_load_data
   );

endinterface : wb_stage_if

// File: rtl/wb_stage_load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Combinational load-data aligner/extender.
//   load_type_i : funct3 (LB, LH, LW, LBU, LHU; others pass the word through)
//   addr_lsb_i  : byte offset; bit 0 is ignored for halfword loads because
//                 misaligned accesses are trapped before this stage
//   load_data_i : raw data-bus word
//   aligned_o   : selected lane, sign- or zero-extended to WORD_WIDTH
// -----------------------------------------------------------------------------
module load_align #(
   parameter int WORD_WIDTH = wb_stage_pkg::WORD_WIDTH
) (
   input  logic [2:0]            load_type_i,
   input  logic [1:0]            addr_lsb_i,
   input  logic [WORD_WIDTH-1:0] load_data_i,
   output logic [WORD_WIDTH-1:0] aligned_o
);

   import wb_stage_pkg::*;

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Lane selection followed by extension according to the load type.
   always_comb begin
      byte_s    = 8'h00;
      half_s    = 16'h0000;
      aligned_o = load_data_i;

      case (addr_lsb_i)
         2'd0:    byte_s = load_data_i[7:0];
         2'd1:    byte_s = load_data_i[15:8];
         2'd2:    byte_s = load_data_i[23:16];
         2'd3:    byte_s = load_data_i[31:24];
         default: byte_s = load_data_i[7:0];
      endcase

      if (addr_lsb_i[1]) begin
         half_s = load_data_i[31:16];
      end else begin
         half_s = load_data_i[15:0];
      end

      case (load_type_i)
         LB:      aligned_o = {{(WORD_WIDTH-8){byte_s[7]}}, byte_s};
         LBU:     aligned_o = {{(WORD_WIDTH-8){1'b0}}, byte_s};
         LH:      aligned_o = {{(WORD_WIDTH-16){half_s[15]}}, half_s};
         LHU:     aligned_o = {{(WORD_WIDTH-16){1'b0}}, half_s};
         LW:      aligned_o = load_data_i;
         default: aligned_o = load_data_i;
      endcase
   end

endmodule : load_align

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
// Writeback pipeline stage between the memory stage and the register file.
//   clk, rst_n  : clock, asynchronous active-low reset
//   mem_if      : memory-stage bundle (wb_stage_if.slave)
//   wb_stall    : hold stage contents
//   wb_flush    : invalidate stage contents (wins over stall and new input)
//   gpr_we_n    : register-file write enable, 0 = write
//   gpr_wr_addr : register-file write index
//   gpr_wr_data : register-file write data (aligned/extended load or ALU)
//   wb_valid    : stage holds a valid instruction
//   wb_rd_addr  : destination tag for hazard logic, 0 when no write pending
//   instret     : retired-instruction counter (wraps)
// Each instruction writes and retires exactly once, in its first valid cycle;
// the fired flag suppresses repeats while the entry is held by a stall.
// -----------------------------------------------------------------------------
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int WORD_WIDTH     = wb_stage_pkg::WORD_WIDTH,
   parameter int GPR_ADDR_WIDTH = wb_stage_pkg::GPR_ADDR_WIDTH,
   parameter int CNT_WIDTH      = wb_stage_pkg::CNT_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst_n,
   wb_stage_if.slave                 mem_if,
   input  logic                      wb_stall,
   input  logic                      wb_flush,
   output logic                      gpr_we_n,
   output logic [GPR_ADDR_WIDTH-1:0] gpr_wr_addr,
   output logic [WORD_WIDTH-1:0]     gpr_wr_data,
   output logic                      wb_valid,
   output logic [GPR_ADDR_WIDTH-1:0] wb_rd_addr,
   output logic [CNT_WIDTH-1:0]      instret
);

   logic                      valid_q,   valid_d;
   logic                      rd_we_q,   rd_we_d;
   logic [GPR_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic [WORD_WIDTH-1:0]     wr_data_q, wr_data_d;
   logic                      fired_q,   fired_d;
   logic                      we_n_q,    we_n_d;
   logic [GPR_ADDR_WIDTH-1:0] tag_q,     tag_d;
   logic [CNT_WIDTH-1:0]      instret_q, instret_d;

   logic [WORD_WIDTH-1:0]     aligned_s;
   logic [WORD_WIDTH-1:0]     result_s;
   logic                      retire_s;
   logic                      pending_s;

   load_align #(
      .WORD_WIDTH (WORD_WIDTH)
   ) u_load_align (
      .load_type_i (mem_if.mem_load_type),
      .addr_lsb_i  (mem_if.mem_addr_lsb),
      .load_data_i (mem_if.mem_load_data),
      .aligned_o   (aligned_s)
   );

   // Next-state for stage registers, fired flag, counter and write port.
   always_comb begin
      valid_d   = valid_q;
      rd_we_d   = rd_we_q;
      rd_addr_d = rd_addr_q;
      wr_data_d = wr_data_q;
      fired_d   = fired_q;
      result_s  = mem_if.mem_alu_result;
      pending_s = 1'b0;

      if (mem_if.mem_is_load) begin
         result_s = aligned_s;
      end else begin
         result_s = mem_if.mem_alu_result;
      end

      if (wb_flush) begin
         valid_d = 1'b0;
         fired_d = 1'b0;
      end else if (wb_stall) begin
         // Held entry is marked fired once its first valid cycle has passed.
         fired_d = fired_q | valid_q;
      end else begin
         valid_d   = mem_if.mem_valid;
         rd_we_d   = mem_if.mem_rd_we;
         rd_addr_d = mem_if.mem_rd_addr;
         wr_data_d = result_s;
         fired_d   = 1'b0;
      end

      // Retirement counts from the current cycle; a flush cannot undo it.
      retire_s  = valid_q & ~fired_q;
      instret_d = instret_q + {{(CNT_WIDTH-1){1'b0}}, retire_s};

      // Write port and hazard tag are precomputed so they leave on flops.
      pending_s = valid_d & rd_we_d & ~fired_d;
      if (pending_s && (rd_addr_d != {GPR_ADDR_WIDTH{1'b0}})) begin
         we_n_d = GPR_WRITE;
      end else begin
         we_n_d = GPR_READ;
      end
      if (pending_s) begin
         tag_d = rd_addr_d;
      end else begin
         tag_d = {GPR_ADDR_WIDTH{1'b0}};
      end
   end

   // Stage state registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         rd_we_q   <= 1'b0;
         rd_addr_q <= {GPR_ADDR_WIDTH{1'b0}};
         wr_data_q <= {WORD_WIDTH{1'b0}};
         fired_q   <= 1'b0;
         we_n_q    <= GPR_READ;
         tag_q     <= {GPR_ADDR_WIDTH{1'b0}};
         instret_q <= {CNT_WIDTH{1'b0}};
      end else begin
         valid_q   <= valid_d;
         rd_we_q   <= rd_we_d;
         rd_addr_q <= rd_addr_d;
         wr_data_q <= wr_data_d;
         fired_q   <= fired_d;
         we_n_q    <= we_n_d;
         tag_q     <= tag_d;
         instret_q <= instret_d;
      end
   end

   assign gpr_we_n    = we_n_q;
   assign gpr_wr_addr = rd_addr_q;
   assign gpr_wr_data = wr_data_q;
   assign wb_valid    = valid_q;
   assign wb_rd_addr  = tag_q;
   assign instret     = instret_q;

endmodule : wb_stage

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage
// Directed, self-checking bench for wb_stage. Expected register-file writes
// are queued when an instruction is driven and matched against the write
// port on the cycle it fires; other outputs are checked at fixed points.
// -----------------------------------------------------------------------------
module tb_wb_stage;

   import wb_stage_pkg::*;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_exp_t;

   typedef struct {
      logic [2:0]  lt;
      logic [1:0]  lsb;
      logic [4:0]  rd;
      logic [31:0] exp;
   } ld_vec_t;

   logic        clk;
   logic        rst_n;
   logic        wb_stall;
   logic        wb_flush;
   logic        gpr_we_n;
   logic [4:0]  gpr_wr_addr;
   logic [31:0] gpr_wr_data;
   logic        wb_valid;
   logic [4:0]  wb_rd_addr;
   logic [63:0] instret;

   int total;
   int bad;
   wr_exp_t sb[$];
   ld_vec_t ld_tab[9];
   logic [63:0] base;

   wb_stage_if mif ();

   wb_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mem_if      (mif),
      .wb_stall    (wb_stall),
      .wb_flush    (wb_flush),
      .gpr_we_n    (gpr_we_n),
      .gpr_wr_addr (gpr_wr_addr),
      .gpr_wr_data (gpr_wr_data),
      .wb_valid    (wb_valid),
      .wb_rd_addr  (wb_rd_addr),
      .instret     (instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total = total + 1;
      assert (obs === exp)
      else begin
         bad = bad + 1;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic we, input logic [4:0] rd,
                        input logic [31:0] alu, input logic ld, input logic [2:0] lt,
                        input logic [1:0] lsb, input logic [31:0] data);
      mif.mem_valid      = v;
      mif.mem_rd_we      = we;
      mif.mem_rd_addr    = rd;
      mif.mem_alu_result = alu;
      mif.mem_is_load    = ld;
      mif.mem_load_type  = lt;
      mif.mem_addr_lsb   = lsb;
      mif.mem_load_data  = data;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 3'b000, 2'd0, 32'h0);
   endtask

   task automatic push(input logic [4:0] a, input logic [31:0] d);
      wr_exp_t e;
      e.addr = a;
      e.data = d;
      sb.push_back(e);
   endtask

   // One clock; then inspect the write port against the scoreboard.
   task automatic step();
      wr_exp_t e;
      @(posedge clk);
      @(negedge clk);
      if (gpr_we_n === 1'b0) begin
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("wr_addr", {59'd0, gpr_wr_addr}, {59'd0, e.addr});
            chk("wr_data", {32'd0, gpr_wr_data}, {32'd0, e.data});
         end else begin
            chk("spurious_write", {63'd0, gpr_we_n}, 64'd1);
         end
      end else begin
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("missing_write", {63'd0, gpr_we_n}, 64'd0);
         end
      end
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      rst_n    = 1'b0;
      wb_stall = 1'b0;
      wb_flush = 1'b0;
      idle();

      ld_tab[0] = '{3'b000, 2'd3, 5'd1,  32'hFFFF_FF80};
      ld_tab[1] = '{3'b100, 2'd3, 5'd2,  32'h0000_0080};
      ld_tab[2] = '{3'b001, 2'd2, 5'd3,  32'hFFFF_80F0};
      ld_tab[3] = '{3'b101, 2'd0, 5'd4,  32'h0000_7F12};
      ld_tab[4] = '{3'b010, 2'd0, 5'd6,  32'h80F0_7F12};
      ld_tab[5] = '{3'b001, 2'd3, 5'd8,  32'hFFFF_80F0};
      ld_tab[6] = '{3'b000, 2'd1, 5'd10, 32'h0000_007F};
      ld_tab[7] = '{3'b011, 2'd1, 5'd11, 32'h80F0_7F12};
      ld_tab[8] = '{3'b101, 2'd2, 5'd12, 32'h0000_80F0};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_valid",   {63'd0, wb_valid}, 64'd0);
      chk("rst_we_n",    {63'd0, gpr_we_n}, 64'd1);
      chk("rst_wr_addr", {59'd0, gpr_wr_addr}, 64'd0);
      chk("rst_wr_data", {32'd0, gpr_wr_data}, 64'd0);
      chk("rst_tag",     {59'd0, wb_rd_addr}, 64'd0);
      chk("rst_instret", instret, 64'd0);
      rst_n = 1'b1;
      step();

      // ALU writeback
      drive(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 3'b000, 2'd0, 32'h0);
      push(5'd5, 32'hDEAD_BEEF);
      step();
      chk("alu_valid",   {63'd0, wb_valid}, 64'd1);
      chk("alu_tag",     {59'd0, wb_rd_addr}, 64'd5);
      chk("alu_instret", instret, 64'd0);
      idle();
      step();
      chk("alu_instret1", instret, 64'd1);
      chk("alu_idle_valid", {63'd0, wb_valid}, 64'd0);
      chk("alu_idle_tag", {59'd0, wb_rd_addr}, 64'd0);

      // Load extension, back-to-back
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, 1'b1, ld_tab[i].rd, 32'h5555_AAAA, 1'b1, ld_tab[i].lt,
               ld_tab[i].lsb, 32'h80F0_7F12);
         push(ld_tab[i].rd, ld_tab[i].exp);
         step();
      end
      // Not a load even though load fields look like one
      drive(1'b1, 1'b1, 5'd13, 32'h0BAD_F00D, 1'b0, 3'b000, 2'd3, 32'h80F0_7F12);
      push(5'd13, 32'h0BAD_F00D);
      step();
      // Invalid instruction with rd_we must not write
      drive(1'b0, 1'b1, 5'd14, 32'h1111_1111, 1'b0, 3'b000, 2'd0, 32'h0);
      step();
      chk("inv_valid", {63'd0, wb_valid}, 64'd0);
      chk("inv_tag", {59'd0, wb_rd_addr}, 64'd0);
      idle();
      step();
      chk("loads_instret", instret, 64'd11);

      // x0 suppression and rd_we=0 still retire
      drive(1'b1, 1'b1, 5'd0, 32'h2222_2222, 1'b0, 3'b000, 2'd0, 32'h0);
      step();
      chk("x0_we_n",  {63'd0, gpr_we_n}, 64'd1);
      chk("x0_tag",   {59'd0, wb_rd_addr}, 64'd0);
      chk("x0_valid", {63'd0, wb_valid}, 64'd1);
      drive(1'b1, 1'b0, 5'd12, 32'h3333_3333, 1'b0, 3'b000, 2'd0, 32'h0);
      step();
      chk("nowe_tag", {59'd0, wb_rd_addr}, 64'd0);
      idle();
      step();
      chk("x0_instret", instret, 64'd13);

      // Stall hold: one write, one retirement over a 4-cycle stall
      base = instret;
      drive(1'b1, 1'b1, 5'd7, 32'h1234_5678, 1'b0, 3'b000, 2'd0, 32'h0);
      push(5'd7, 32'h1234_5678);
      step();
      chk("stall_tag0", {59'd0, wb_rd_addr}, 64'd7);
      wb_stall = 1'b1;
      drive(1'b1, 1'b1, 5'd20, 32'hFFFF_0000, 1'b0, 3'b000, 2'd0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("stall_valid", {63'd0, wb_valid}, 64'd1);
         chk("stall_addr",  {59'd0, gpr_wr_addr}, 64'd7);
         chk("stall_data",  {32'd0, gpr_wr_data}, 64'h1234_5678);
         chk("stall_tag",   {59'd0, wb_rd_addr}, 64'd0);
         chk("stall_instret", instret, base + 64'd1);
      end
      wb_stall = 1'b0;
      idle();
      step();
      chk("unstall_valid", {63'd0, wb_valid}, 64'd0);
      chk("unstall_instret", instret, base + 64'd1);

      // Flush priority over stall and new input
      base = instret;
      drive(1'b1, 1'b1, 5'd9, 32'h9999_9999, 1'b0, 3'b000, 2'd0, 32'h0);
      push(5'd9, 32'h9999_9999);
      step();
      wb_stall = 1'b1;
      wb_flush = 1'b1;
      drive(1'b1, 1'b1, 5'd21, 32'hAAAA_0001, 1'b0, 3'b000, 2'd0, 32'h0);
      step();
      chk("flush_valid", {63'd0, wb_valid}, 64'd0);
      chk("flush_tag",   {59'd0, wb_rd_addr}, 64'd0);
      wb_flush = 1'b0;
      step();
      step();
      chk("flush_stall_valid", {63'd0, wb_valid}, 64'd0);
      chk("flush_instret", instret, base + 64'd1);
      // Entry arriving with stall+flush is dropped: no write, no retire
      wb_flush = 1'b1;
      drive(1'b1, 1'b1, 5'd22, 32'hAAAA_0002, 1'b0, 3'b000, 2'd0, 32'h0);
      step();
      wb_flush = 1'b0;
      wb_stall = 1'b0;
      idle();
      step();
      chk("drop_valid", {63'd0, wb_valid}, 64'd0);
      chk("drop_instret", instret, base + 64'd1);

      // Counter wrap
      force dut.instret_q = {64{1'b1}};
      #1;
      release dut.instret_q;
      chk("wrap_preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
      drive(1'b1, 1'b1, 5'd15, 32'h0000_000F, 1'b0, 3'b000, 2'd0, 32'h0);
      push(5'd15, 32'h0000_000F);
      step();
      chk("wrap_max", instret, 64'hFFFF_FFFF_FFFF_FFFF);
      drive(1'b1, 1'b1, 5'd16, 32'h0000_0010, 1'b0, 3'b000, 2'd0, 32'h0);
      push(5'd16, 32'h0000_0010);
      step();
      chk("wrap_zero", instret, 64'd0);
      idle();
      step();
      chk("wrap_one", instret, 64'd1);

      // Reset in the middle of a write under stall
      drive(1'b1, 1'b1, 5'd17, 32'h1717_1717, 1'b0, 3'b000, 2'd0, 32'h0);
      push(5'd17, 32'h1717_1717);
      step();
      wb_stall = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("mrst_we_n",    {63'd0, gpr_we_n}, 64'd1);
      chk("mrst_valid",   {63'd0, wb_valid}, 64'd0);
      chk("mrst_addr",    {59'd0, gpr_wr_addr}, 64'd0);
      chk("mrst_data",    {32'd0, gpr_wr_data}, 64'd0);
      chk("mrst_tag",     {59'd0, wb_rd_addr}, 64'd0);
      chk("mrst_instret", instret, 64'd0);
      step();
      @(negedge clk);
      rst_n = 1'b1;
      step();
      step();
      wb_stall = 1'b0;
      idle();
      step();
      chk("post_rst_valid", {63'd0, wb_valid}, 64'd0);
      chk("post_rst_instret", instret, 64'd0);

      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_wb_stage
